// File: rtl/u2_to_sm.sv
`default_nettype none
// ============================================================================
// Module   : u2_to_sm
// Purpose  : Bit-serial two's-complement (U2) to sign-magnitude decoder.
//            A WIDTH-bit U2 word is accepted through a valid/ready handshake,
//            processed LSB-first one bit per clock using the "copy up to and
//            including the first 1, then invert" negation rule, and the
//            resulting sign / magnitude is presented through a second
//            valid/ready handshake.
// Ports    : clk        - rising-edge clock
//            rst_n      - asynchronous active-low reset
//            in_valid   - in_data holds a word to convert
//            in_ready   - block can accept a word (IDLE only)
//            in_data    - WIDTH-bit U2 word
//            out_valid  - sign/mag/ovf hold a completed conversion
//            out_ready  - consumer accepts the result
//            sign       - 1 when the input was negative
//            mag        - WIDTH-1 bit magnitude
//            ovf        - magnitude does not fit (input == -2^(WIDTH-1))
// Config   : U2DEC_OVF_EN - when defined, the result MSB is kept and drives
//            ovf; when undefined, ovf is tied low and that bit is not built.
// Revision : 1.0 - initial release
// ============================================================================
module u2_to_sm #(
    parameter int WIDTH = 5
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_data,
    output logic             out_valid,
    input  logic             out_ready,
    output logic             sign,
    output logic [WIDTH-2:0] mag,
    output logic             ovf
);

    localparam int c_cnt_w = (WIDTH > 2) ? $clog2(WIDTH) : 1;
    localparam logic [c_cnt_w-1:0] c_cnt_last = c_cnt_w'(WIDTH - 1);
    localparam logic [c_cnt_w-1:0] c_cnt_one  = c_cnt_w'(1);

`ifdef U2DEC_OVF_EN
    localparam int c_res_w = WIDTH;
`else
    localparam int c_res_w = WIDTH - 1;
`endif

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } state_t;

    state_t               state_q,  state_d;
    logic [WIDTH-1:0]     shift_q,  shift_d;
    logic [c_res_w-1:0]   res_q,    res_d;
    logic [c_cnt_w-1:0]   cnt_q,    cnt_d;
    logic                 found_q,  found_d;
    logic                 sign_q,   sign_d;

    logic                 w_bit;
    logic                 w_rbit;
    logic                 w_res_en;
    logic [c_res_w-1:0]   w_res_shift;

    // Current bit and its converted value: inverted only once a 1 has
    // already been passed in a negative word.
    assign w_bit  = shift_q[0];
    assign w_rbit = w_bit ^ (sign_q & found_q);

    // Result bits enter from the MSB side so bit 0 ends up at res_q[0].
    generate
        if (c_res_w > 1) begin : g_res_wide
            assign w_res_shift = {w_rbit, res_q[c_res_w-1:1]};
        end else begin : g_res_narrow
            assign w_res_shift = w_rbit;
        end
    endgenerate

`ifdef U2DEC_OVF_EN
    assign w_res_en = 1'b1;
    assign ovf      = res_q[WIDTH-1];
`else
    // Without the MSB bit the final (sign-position) result bit is dropped,
    // so the register stops shifting on the last SHIFT cycle.
    assign w_res_en = (cnt_q != c_cnt_last);
    assign ovf      = 1'b0;
`endif

    assign mag  = res_q[WIDTH-2:0];
    assign sign = sign_q;

    always_comb begin
        state_d   = state_q;
        shift_d   = shift_q;
        res_d     = res_q;
        cnt_d     = cnt_q;
        found_d   = found_q;
        sign_d    = sign_q;
        in_ready  = 1'b0;
        out_valid = 1'b0;

        case (state_q)
            IDLE: begin
                in_ready = 1'b1;
                if (in_valid) begin
                    shift_d = in_data;
                    sign_d  = in_data[WIDTH-1];
                    found_d = 1'b0;
                    cnt_d   = '0;
                    state_d = SHIFT;
                end
            end
            SHIFT: begin
                shift_d = {1'b0, shift_q[WIDTH-1:1]};
                found_d = found_q | (sign_q & w_bit);
                if (w_res_en) begin
                    res_d = w_res_shift;
                end
                if (cnt_q == c_cnt_last) begin
                    state_d = DONE;
                end else begin
                    cnt_d = cnt_q + c_cnt_one;
                end
            end
            DONE: begin
                out_valid = 1'b1;
                if (out_ready) begin
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            shift_q <= '0;
            res_q   <= '0;
            cnt_q   <= '0;
            found_q <= 1'b0;
            sign_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            shift_q <= shift_d;
            res_q   <= res_d;
            cnt_q   <= cnt_d;
            found_q <= found_d;
            sign_q  <= sign_d;
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_u2_to_sm.sv
`default_nettype none
// ============================================================================
// Module   : tb_u2_to_sm
// Purpose  : Self-checking bench for u2_to_sm (WIDTH=5). Stimulus pushes the
//            hand-computed expected result into a queue; a monitor pops and
//            compares on every output handshake.
// Revision : 1.0 - initial release
// ============================================================================
module tb_u2_to_sm;

    localparam int W = 5;

`ifdef U2DEC_OVF_EN
    localparam logic c_ovf_min = 1'b1;
`else
    localparam logic c_ovf_min = 1'b0;
`endif

    logic         clk = 1'b0;
    logic         rst_n;
    logic         in_valid;
    logic         in_ready;
    logic [W-1:0] in_data;
    logic         out_valid;
    logic         out_ready;
    logic         sign;
    logic [W-2:0] mag;
    logic         ovf;

    always #5 clk = ~clk;

    u2_to_sm #(.WIDTH(W)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .sign      (sign),
        .mag       (mag),
        .ovf       (ovf)
    );

    typedef struct packed {
        logic         s;
        logic [W-2:0] m;
        logic         o;
    } exp_t;

    exp_t exp_q[$];
    int   n_cmp = 0;
    int   n_bad = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] req);
        n_cmp++;
        if (act !== req) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, act, req, $time);
        end
    endtask

    task automatic timeout_fail(input string nm);
        n_cmp++;
        n_bad++;
        $display("FAIL %s: timed out (t=%0t)", nm, $time);
    endtask

    // Called at posedge+1; returns at posedge+1 after the accepting edge.
    task automatic send(input logic [W-1:0] d, input logic es, input logic [W-2:0] em,
                        input logic eo);
        exp_t e;
        int   t;
        t = 0;
        while (!in_ready && t < 100) begin
            @(posedge clk); #1;
            t++;
        end
        if (!in_ready) timeout_fail("send_wait_ready");
        e.s = es;
        e.m = em;
        e.o = eo;
        exp_q.push_back(e);
        in_valid = 1'b1;
        in_data  = d;
        @(posedge clk); #1;
        in_valid = 1'b0;
        in_data  = W'($urandom);
    endtask

    task automatic wait_empty();
        int t;
        t = 0;
        while (exp_q.size() != 0 && t < 200) begin
            @(posedge clk); #1;
            t++;
        end
        if (exp_q.size() != 0) timeout_fail("drain");
    endtask

    // Monitor: compare on each output handshake, then confirm the block
    // dropped out_valid and returned to IDLE on the following cycle.
    initial begin
        exp_t e;
        bit   prev_hs;
        prev_hs = 1'b0;
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                prev_hs = 1'b0;
            end else begin
                if (prev_hs) begin
                    chk("post_hs_out_valid", 32'(out_valid), 32'd0);
                    chk("post_hs_in_ready",  32'(in_ready),  32'd1);
                end
                prev_hs = 1'b0;
                if (out_valid && out_ready) begin
                    if (exp_q.size() == 0) begin
                        n_cmp++;
                        n_bad++;
                        $display("FAIL unexpected_output: sign=%0b mag=%0h ovf=%0b", sign, mag, ovf);
                    end else begin
                        e = exp_q.pop_front();
                        chk("sign", 32'(sign), 32'(e.s));
                        chk("mag",  32'(mag),  32'(e.m));
                        chk("ovf",  32'(ovf),  32'(e.o));
                    end
                    prev_hs = 1'b1;
                end
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int t;
        rst_n     = 1'b0;
        in_valid  = 1'b0;
        in_data   = '0;
        out_ready = 1'b1;
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;

        // Reset / idle state
        @(negedge clk);
        chk("rst_in_ready",  32'(in_ready),  32'd1);
        chk("rst_out_valid", 32'(out_valid), 32'd0);
        chk("rst_sign",      32'(sign),      32'd0);
        chk("rst_mag",       32'(mag),       32'd0);
        chk("rst_ovf",       32'(ovf),       32'd0);
        @(posedge clk); #1;

        // Back-to-back directed conversions
        send(5'b00101, 1'b0, 4'b0101, 1'b0);
        send(5'b11011, 1'b1, 4'b0101, 1'b0);   // -5
        send(5'b11111, 1'b1, 4'b0001, 1'b0);   // -1
        send(5'b10000, 1'b1, 4'b0000, c_ovf_min); // -16
        send(5'b00000, 1'b0, 4'b0000, 1'b0);
        send(5'b10001, 1'b1, 4'b1111, 1'b0);   // -15
        send(5'b01010, 1'b0, 4'b1010, 1'b0);
        wait_empty();

        // Backpressure: -7 held in DONE while inputs toggle
        out_ready = 1'b0;
        send(5'b11001, 1'b1, 4'b0111, 1'b0);
        t = 0;
        while (!out_valid && t < 50) begin
            @(posedge clk); #1;
            t++;
        end
        if (!out_valid) timeout_fail("stall_wait_valid");
        for (int i = 0; i < 10; i++) begin
            in_valid = 1'($urandom);
            in_data  = W'($urandom);
            @(negedge clk);
            chk("stall_in_ready",  32'(in_ready),  32'd0);
            chk("stall_out_valid", 32'(out_valid), 32'd1);
            chk("stall_sign",      32'(sign),      32'd1);
            chk("stall_mag",       32'(mag),       32'd7);
            chk("stall_ovf",       32'(ovf),       32'd0);
            @(posedge clk); #1;
        end

        // Release with a new word already offered; accepted only from IDLE
        begin
            exp_t e;
            e.s = 1'b0;
            e.m = 4'b0110;
            e.o = 1'b0;
            out_ready = 1'b1;
            in_valid  = 1'b1;
            in_data   = 5'b00110;
            exp_q.push_back(e);
        end
        @(posedge clk); #1;
        chk("release_in_ready", 32'(in_ready), 32'd1);
        @(posedge clk); #1;
        in_valid = 1'b0;
        chk("accepted_in_ready", 32'(in_ready), 32'd0);
        wait_empty();

        // Abort -5 in its third SHIFT cycle
        @(posedge clk); #1;
        in_valid = 1'b1;
        in_data  = 5'b11011;
        @(posedge clk); #1;           // SHIFT cycle 1
        in_valid = 1'b0;
        @(posedge clk); #1;           // SHIFT cycle 2
        @(posedge clk); #1;           // SHIFT cycle 3
        chk("abort_pre_sign", 32'(sign), 32'd1);
        rst_n = 1'b0;
        #1;
        chk("abort_sign",      32'(sign),      32'd0);
        chk("abort_mag",       32'(mag),       32'd0);
        chk("abort_ovf",       32'(ovf),       32'd0);
        chk("abort_out_valid", 32'(out_valid), 32'd0);
        chk("abort_in_ready",  32'(in_ready),  32'd1);
        @(posedge clk); #1;
        rst_n = 1'b1;
        @(posedge clk); #1;
        send(5'b01111, 1'b0, 4'b1111, 1'b0);
        wait_empty();

        repeat (3) @(posedge clk);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
`default_nettype wire
